// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM handshake state and the memory
// controller arbitration state.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      INSTR = 2'd2
   } memctl_state_t;

endpackage

// File: rtl/memctl_watchdog.sv
// Saturating cycle counter used to bound how long a granted RAM access may
// wait. Clear wins over enable; a TIMEOUT of 0 keeps the flag low forever.
module memctl_watchdog #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 8
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             i_clear,
   input  logic             i_enable,
   output logic [CNT_W-1:0] o_count,
   output logic             o_timeout
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
   localparam logic [CNT_W-1:0] MAXCNT = '1;

   logic [CNT_W-1:0] r_count;

   // Count owned cycles, holding at the top value instead of wrapping.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != MAXCNT)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count   = r_count;
   assign o_timeout = (TIMEOUT > 0) && i_enable && (r_count == LIMIT);

endmodule

// File: rtl/memory_control.sv
// Memory-side responder for the caches: arbitrates instruction and data
// requests onto a single-port RAM with round-robin fairness, reports RAM
// errors and aborts accesses that wait too long.
module memory_control
   import cpu_types_pkg::*;
#(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 8
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        i_iREN,
   input  logic        i_dREN,
   input  logic        i_dWEN,
   input  logic [31:0] i_iaddr,
   input  logic [31:0] i_daddr,
   input  logic [31:0] i_dstore,
   output logic        o_iwait,
   output logic        o_dwait,
   output logic [31:0] o_iload,
   output logic [31:0] o_dload,
   output logic        o_ramREN,
   output logic        o_ramWEN,
   output logic [31:0] o_ramaddr,
   output logic [31:0] o_ramstore,
   input  logic [31:0] i_ramload,
   input  logic [1:0]  i_ramstate,
   output logic        o_mem_err
);

   memctl_state_t r_state;
   memctl_state_t w_nextState;
   memctl_state_t r_lastGrant;
   ramstate_t     w_ramState;
   logic          w_dreq;
   logic          w_ireq;
   logic          w_complete;
   logic          w_timeout;
   logic          w_owned;
   logic [CNT_W-1:0] w_count;

   assign w_ramState = ramstate_t'(i_ramstate);
   assign w_dreq     = i_dREN | i_dWEN;
   assign w_ireq     = i_iREN;
   assign w_owned    = (r_state != IDLE);

   memctl_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_watchdog (
      .CLK       (CLK),
      .nRST      (nRST),
      .i_clear   (!w_owned),
      .i_enable  (w_owned),
      .o_count   (w_count),
      .o_timeout (w_timeout)
   );

   // Arbitration state and the owner of the last completed access.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         r_state     <= IDLE;
         r_lastGrant <= INSTR;
      end else begin
         r_state <= w_nextState;
         if (w_complete) begin
            r_lastGrant <= r_state;
         end
      end
   end

   // Grant decision, RAM drive and completion/error signalling for the owner.
   always_comb begin
      w_nextState = r_state;
      w_complete  = 1'b0;
      o_iwait     = 1'b1;
      o_dwait     = 1'b1;
      o_iload     = '0;
      o_dload     = '0;
      o_ramREN    = 1'b0;
      o_ramWEN    = 1'b0;
      o_ramaddr   = '0;
      o_ramstore  = '0;
      o_mem_err   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_dreq && w_ireq) begin
               w_nextState = (r_lastGrant == DATA) ? INSTR : DATA;
            end else if (w_dreq) begin
               w_nextState = DATA;
            end else if (w_ireq) begin
               w_nextState = INSTR;
            end
         end
         DATA: begin
            o_ramaddr = i_daddr;
            if (i_dWEN) begin
               o_ramWEN   = 1'b1;
               o_ramstore = i_dstore;
            end else if (i_dREN) begin
               o_ramREN = 1'b1;
            end
            if (!w_dreq) begin
               w_nextState = IDLE;
            end else if (w_ramState == ACCESS) begin
               w_complete  = 1'b1;
               w_nextState = IDLE;
               if (nRST) begin
                  o_dwait = 1'b0;
                  o_dload = i_ramload;
               end
            end else if ((w_ramState == ERROR) || w_timeout) begin
               o_mem_err   = nRST;
               w_nextState = IDLE;
            end
         end
         INSTR: begin
            o_ramaddr = i_iaddr;
            o_ramREN  = i_iREN;
            if (!w_ireq) begin
               w_nextState = IDLE;
            end else if (w_ramState == ACCESS) begin
               w_complete  = 1'b1;
               w_nextState = IDLE;
               if (nRST) begin
                  o_iwait = 1'b0;
                  o_iload = i_ramload;
               end
            end else if ((w_ramState == ERROR) || w_timeout) begin
               o_mem_err   = nRST;
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_memory_control.sv
// Directed bench for memory_control: a default instance (TIMEOUT=64) and a
// short-watchdog instance (TIMEOUT=4) share all inputs.
module tb_memory_control;
   import cpu_types_pkg::*;

   logic        CLK;
   logic        nRST;
   logic        iREN, dREN, dWEN;
   logic [31:0] iaddr, daddr, dstore, ramload;
   logic [1:0]  ramstate;

   logic        iwait, dwait, ramREN, ramWEN, memErr;
   logic [31:0] iload, dload, ramaddr, ramstore;
   logic        iwaitB, dwaitB, ramRENB, ramWENB, memErrB;
   logic [31:0] iloadB, dloadB, ramaddrB, ramstoreB;

   int nChecks = 0;
   int nFails  = 0;

   memory_control dut (
      .CLK(CLK), .nRST(nRST), .i_iREN(iREN), .i_dREN(dREN), .i_dWEN(dWEN),
      .i_iaddr(iaddr), .i_daddr(daddr), .i_dstore(dstore),
      .o_iwait(iwait), .o_dwait(dwait), .o_iload(iload), .o_dload(dload),
      .o_ramREN(ramREN), .o_ramWEN(ramWEN), .o_ramaddr(ramaddr), .o_ramstore(ramstore),
      .i_ramload(ramload), .i_ramstate(ramstate), .o_mem_err(memErr)
   );

   memory_control #(.TIMEOUT(4), .CNT_W(8)) dutB (
      .CLK(CLK), .nRST(nRST), .i_iREN(iREN), .i_dREN(dREN), .i_dWEN(dWEN),
      .i_iaddr(iaddr), .i_daddr(daddr), .i_dstore(dstore),
      .o_iwait(iwaitB), .o_dwait(dwaitB), .o_iload(iloadB), .o_dload(dloadB),
      .o_ramREN(ramRENB), .o_ramWEN(ramWENB), .o_ramaddr(ramaddrB), .o_ramstore(ramstoreB),
      .i_ramload(ramload), .i_ramstate(ramstate), .o_mem_err(memErrB)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic resetDut();
      nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;
      tick();
      tick();
   endtask

   task automatic test_reset();
      resetDut();
      nChecks++; if (iwait !== 1'b1) begin nFails++; $display("[TB] FAIL reset_iwait got %0b want 1", iwait); end
      nChecks++; if (dwait !== 1'b1) begin nFails++; $display("[TB] FAIL reset_dwait got %0b want 1", dwait); end
      nChecks++; if (iload !== 32'h0 || dload !== 32'h0) begin nFails++; $display("[TB] FAIL reset_loads got %h/%h want 0/0", iload, dload); end
      nChecks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0) begin nFails++; $display("[TB] FAIL reset_enables got %0b/%0b want 0/0", ramREN, ramWEN); end
      nChecks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin nFails++; $display("[TB] FAIL reset_ramaddr_store got %h/%h want 0/0", ramaddr, ramstore); end
      nChecks++; if (memErr !== 1'b0) begin nFails++; $display("[TB] FAIL reset_mem_err got %0b want 0", memErr); end
      nRST = 1'b1;
      tick();
   endtask

   task automatic test_ifetch();
      iREN = 1; iaddr = 32'h40; ramstate = FREE;
      settle();
      nChecks++; if (ramREN !== 1'b0 || iwait !== 1'b1) begin nFails++; $display("[TB] FAIL ifetch_request_cycle ramREN=%0b iwait=%0b want 0/1", ramREN, iwait); end
      tick();
      ramstate = ACCESS; ramload = 32'h8C010004;
      settle();
      nChecks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin nFails++; $display("[TB] FAIL ifetch_drive ramREN=%0b ramaddr=%h want 1/00000040", ramREN, ramaddr); end
      nChecks++; if (iwait !== 1'b0 || iload !== 32'h8C010004) begin nFails++; $display("[TB] FAIL ifetch_complete iwait=%0b iload=%h want 0/8c010004", iwait, iload); end
      nChecks++; if (dwait !== 1'b1) begin nFails++; $display("[TB] FAIL ifetch_dwait got %0b want 1", dwait); end
      tick();
      iREN = 0; ramstate = FREE;
      settle();
      nChecks++; if (iwait !== 1'b1 || ramREN !== 1'b0) begin nFails++; $display("[TB] FAIL ifetch_after iwait=%0b ramREN=%0b want 1/0", iwait, ramREN); end
      tick();
   endtask

   task automatic test_write();
      dWEN = 1; daddr = 32'h100; dstore = 32'hDEADBEEF; ramstate = BUSY;
      tick();
      for (int k = 0; k < 3; k++) begin
         ramstate = (k < 2) ? BUSY : ACCESS;
         settle();
         nChecks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramaddr !== 32'h100 || ramstore !== 32'hDEADBEEF) begin
            nFails++; $display("[TB] FAIL write_hold[%0d] WEN=%0b REN=%0b addr=%h store=%h want 1/0/100/deadbeef", k, ramWEN, ramREN, ramaddr, ramstore);
         end
         nChecks++; if (dwait !== ((k == 2) ? 1'b0 : 1'b1)) begin nFails++; $display("[TB] FAIL write_dwait[%0d] got %0b want %0b", k, dwait, (k == 2) ? 1'b0 : 1'b1); end
         tick();
      end
      dWEN = 0; ramstate = FREE;
      settle();
      nChecks++; if (ramWEN !== 1'b0 || dwait !== 1'b1) begin nFails++; $display("[TB] FAIL write_after WEN=%0b dwait=%0b want 0/1", ramWEN, dwait); end
      tick();
   endtask

   task automatic test_round_robin();
      logic seq [4];
      int   nDone;
      resetDut();
      nRST = 1; iREN = 1; dREN = 1; iaddr = 32'h40; daddr = 32'h200;
      ramstate = ACCESS; ramload = 32'h12345678;
      nDone = 0;
      for (int c = 0; c < 20 && nDone < 4; c++) begin
         settle();
         nChecks++; if (iwait === 1'b0 && dwait === 1'b0) begin nFails++; $display("[TB] FAIL rr_both_wait_low cycle %0d iwait=%0b dwait=%0b", c, iwait, dwait); end
         if (dwait === 1'b0) begin seq[nDone] = 1'b0; nDone++; end
         else if (iwait === 1'b0) begin seq[nDone] = 1'b1; nDone++; end
         tick();
      end
      nChecks++; if (nDone !== 4) begin nFails++; $display("[TB] FAIL rr_count got %0d want 4", nDone); end
      for (int k = 0; k < nDone; k++) begin
         nChecks++; if (seq[k] !== k[0]) begin nFails++; $display("[TB] FAIL rr_order[%0d] got %s want %s", k, seq[k] ? "INSTR" : "DATA", k[0] ? "INSTR" : "DATA"); end
      end
      iREN = 0; dREN = 0; ramstate = FREE;
      tick();
      tick();
   endtask

   task automatic test_error();
      dREN = 1; daddr = 32'h300; ramstate = ERROR;
      tick();
      settle();
      nChecks++; if (memErr !== 1'b1 || dwait !== 1'b1 || ramREN !== 1'b1) begin nFails++; $display("[TB] FAIL err_pulse mem_err=%0b dwait=%0b ramREN=%0b want 1/1/1", memErr, dwait, ramREN); end
      tick();
      ramstate = FREE;
      settle();
      nChecks++; if (memErr !== 1'b0 || dwait !== 1'b1 || ramREN !== 1'b0) begin nFails++; $display("[TB] FAIL err_idle mem_err=%0b dwait=%0b ramREN=%0b want 0/1/0", memErr, dwait, ramREN); end
      tick();
      ramstate = ACCESS; ramload = 32'hCAFEF00D;
      settle();
      nChecks++; if (dwait !== 1'b0 || dload !== 32'hCAFEF00D || memErr !== 1'b0) begin nFails++; $display("[TB] FAIL err_retry dwait=%0b dload=%h mem_err=%0b want 0/cafef00d/0", dwait, dload, memErr); end
      tick();
      dREN = 0; ramstate = FREE;
      tick();
   endtask

   task automatic test_timeout();
      iREN = 1; iaddr = 32'h80; ramstate = BUSY;
      tick();
      for (int k = 1; k <= 4; k++) begin
         settle();
         nChecks++; if (memErrB !== ((k == 4) ? 1'b1 : 1'b0) || iwaitB !== 1'b1 || ramRENB !== 1'b1) begin
            nFails++; $display("[TB] FAIL wdog_cycle[%0d] mem_err=%0b iwait=%0b ramREN=%0b want %0b/1/1", k, memErrB, iwaitB, ramRENB, (k == 4) ? 1'b1 : 1'b0);
         end
         nChecks++; if (memErr !== 1'b0) begin nFails++; $display("[TB] FAIL wdog_long_timeout[%0d] mem_err=%0b want 0", k, memErr); end
         tick();
      end
      settle();
      nChecks++; if (ramRENB !== 1'b0 || memErrB !== 1'b0) begin nFails++; $display("[TB] FAIL wdog_idle ramREN=%0b mem_err=%0b want 0/0", ramRENB, memErrB); end
      tick();
      ramstate = ACCESS; ramload = 32'h0BADF00D;
      settle();
      nChecks++; if (ramRENB !== 1'b1 || ramaddrB !== 32'h80 || iwaitB !== 1'b0 || iloadB !== 32'h0BADF00D) begin
         nFails++; $display("[TB] FAIL wdog_regrant REN=%0b addr=%h iwait=%0b iload=%h want 1/80/0/0badf00d", ramRENB, ramaddrB, iwaitB, iloadB);
      end
      tick();
      iREN = 0; ramstate = FREE;
      tick();
   endtask

   task automatic test_reset_mid();
      dWEN = 1; daddr = 32'h500; dstore = 32'h55AA55AA; ramstate = BUSY;
      tick();
      settle();
      nChecks++; if (ramWEN !== 1'b1) begin nFails++; $display("[TB] FAIL rstmid_owned ramWEN=%0b want 1", ramWEN); end
      nRST = 0; ramstate = ACCESS;
      settle();
      nChecks++; if (dwait !== 1'b1) begin nFails++; $display("[TB] FAIL rstmid_no_complete dwait=%0b want 1", dwait); end
      tick();
      nChecks++; if (ramWEN !== 1'b0 || dwait !== 1'b1 || ramaddr !== 32'h0) begin nFails++; $display("[TB] FAIL rstmid_after WEN=%0b dwait=%0b addr=%h want 0/1/0", ramWEN, dwait, ramaddr); end
      nRST = 1; dWEN = 0; ramstate = FREE;
      tick();
      settle();
      nChecks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0 || memErr !== 1'b0) begin nFails++; $display("[TB] FAIL rstmid_idle WEN=%0b REN=%0b mem_err=%0b want 0/0/0", ramWEN, ramREN, memErr); end
   endtask

   // Run every scenario in order and report.
   initial begin
      test_reset();
      test_ifetch();
      test_write();
      test_round_robin();
      test_error();
      test_timeout();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/memory_control.md
Name: memory_control

Overview:
- Memory-side responder of cache_control_if. Receives instruction and data requests from the caches block (iREN/dREN/dWEN/iaddr/daddr/dstore) and arbitrates them onto the single-port RAM.
- Returns iwait/dwait/iload/dload to the caches.
- Sits between caches and the RAM model/controller. Owns request ordering, fairness and the access watchdog.

Parameters:
- TIMEOUT, 64: cycles a granted access may wait for ramstate==ACCESS before abort; 0 disables the watchdog.
- CNT_W, 8: watchdog counter width; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  synchronous active-low reset
- ccif.iREN  in  1  instruction read request
- ccif.dREN  in  1  data read request
- ccif.dWEN  in  1  data write request
- ccif.iaddr  in  32  instruction address (word_t)
- ccif.daddr  in  32  data address (word_t)
- ccif.dstore  in  32  data write value
- ccif.iwait  out  1  0 only in the cycle an instruction read completes
- ccif.dwait  out  1  0 only in the cycle a data access completes
- ccif.iload  out  32  instruction read data, valid when iwait==0
- ccif.dload  out  32  data read data, valid when dwait==0
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data, valid when ramstate==ACCESS
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR
- mem_err  out  1  one-cycle pulse on ERROR or watchdog abort

Behaviour:
- One clock domain (CLK). Reset is synchronous and active-low (nRST).
- Reset values:
  - state=IDLE, last_grant=INSTR, watchdog count=0.
  - iwait=1, dwait=1, iload=0, dload=0.
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, mem_err=0.
- Reset asserted mid-access drops the RAM enables on the next edge. No completion is signalled.
- FSM states: IDLE, DATA, INSTR.
  - IDLE: RAM enables are 0.
  - Requests pending: dreq=dREN|dWEN, ireq=iREN.
  - If only one request is pending, go to that owner.
  - If both are pending, grant the owner opposite to last_grant (round-robin). Reset value of last_grant favours DATA first.
  - The grant decision is registered. The RAM is first driven in the cycle after the request is seen, so minimum request-to-completion latency is 2 cycles with a zero-wait RAM.
- DATA state:
  - ramaddr=daddr.
  - If dWEN: ramWEN=1, ramstore=dstore. Otherwise ramREN=1.
  - dWEN and dREN both high is treated as a write.
- INSTR state: ramREN=1, ramaddr=iaddr.
- Completion happens when ramstate==ACCESS while owned:
  - Lower the owner's wait combinationally in that cycle.
  - Drive the owner's load with ramload (dload on a write is don't-care, driven with ramload).
  - Set last_grant=owner and return to IDLE on the next edge.
  - The non-owner's wait stays 1.
- ramstate FREE/BUSY while owned: hold all RAM outputs stable. Address and data track the requester's inputs; the caches hold them stable by protocol.
- ramstate ERROR while owned:
  - Pulse mem_err for 1 cycle and return to IDLE.
  - The owner's wait stays 1, so the requester retries naturally.
- Withdrawal: if the owner's enable drops before completion, go to IDLE next edge with no completion and no mem_err.
- Watchdog:
  - Counts cycles in DATA/INSTR and clears on entry to IDLE.
  - With TIMEOUT>0, when count==TIMEOUT-1 and ramstate!=ACCESS: abort to IDLE and pulse mem_err. The owner retries.
  - The counter saturates and never wraps.
- iwait and dwait are never both 0 in the same cycle.

Decomposition:
- cpu_types_pkg: word_t (existing), ramstate_t {FREE, BUSY, ACCESS, ERROR} (existing), new memctl_state_t {IDLE, DATA, INSTR}.
- One natural sub-module: memctl_watchdog (parameterised saturating counter with clear/enable and timeout flag).
- The arbiter FSM stays in memory_control.

Test Plan:
- Instruction fetch, 0-wait RAM: iREN=1, iaddr=0x40, RAM returns ACCESS in first driven cycle with ramload=0x8C010004 -> iwait=0 exactly 2 cycles after request, iload=0x8C010004, dwait stays 1.
- Data write, 3-cycle RAM (BUSY, BUSY, ACCESS): dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF held 3 cycles, then dwait=0 for one cycle.
- Simultaneous steady iREN and dREN, 0-wait RAM -> after reset the sequence of completions is DATA, INSTR, DATA, INSTR. iwait and dwait are never both 0.
- ramstate=ERROR on a data read -> mem_err pulses 1 cycle and dwait stays 1. The retry completes next ACCESS with dload=ramload.
- TIMEOUT=4, RAM stuck BUSY on an instruction read -> abort after 4 owned cycles, mem_err=1 for one cycle, FSM re-grants INSTR.
- nRST=0 during DATA with ramWEN=1 -> next edge ramWEN=0, dwait=1, state IDLE, no completion pulse.
